// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port external memory: critical-word-first
// I-cache line refills and single-word data loads/stores, alternating priority.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  localparam int L         = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_word,
  output logic [L-1:0]      i_word_idx,
  output logic              i_word_ready,
  output logic              i_line_done,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] I_ISSUE = 3'd1;
  localparam logic [2:0] I_WAIT  = 3'd2;
  localparam logic [2:0] D_RD    = 3'd3;
  localparam logic [2:0] D_WAIT  = 3'd4;
  localparam logic [2:0] D_WR    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [L:0] CNT_FULL = (L+1)'(LINE_WORDS);
  localparam logic [L:0] CNT_LAST = (L+1)'(LINE_WORDS - 1);
  localparam logic [L:0] CNT_ONE  = (L+1)'(1);

  logic [2:0]        state;
  logic              last_grant_i;
  logic              done_is_i;
  logic [L:0]        issue_cnt;
  logic [L:0]        recv_cnt;
  logic [ADDR_W-1:0] i_addr_q;
  logic [ADDR_W-1:0] d_addr_q;
  logic [DATA_W-1:0] d_wdata_q;

  logic              want_i;
  logic              want_d;
  logic              grant_i;
  logic              grant_d;
  logic              i_accept;
  logic [L:0]        recv_next;
  logic [L-1:0]      issue_idx;
  logic [L-1:0]      recv_idx;

  // Refill responses are accepted in any refill state, but never past a full line.
  always_comb begin
    want_i    = i_miss;
    want_d    = d_re | d_we;
    grant_i   = want_i && (!want_d || !last_grant_i);
    grant_d   = want_d && !grant_i;
    i_accept  = mem_rvalid && (state == I_ISSUE || state == I_WAIT) && (recv_cnt < CNT_FULL);
    recv_next = recv_cnt + {{L{1'b0}}, i_accept};
    issue_idx = i_addr_q[L-1:0] + issue_cnt[L-1:0];
    recv_idx  = i_addr_q[L-1:0] + recv_cnt[L-1:0];
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      I_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = {i_addr_q[ADDR_W-1:L], issue_idx};
      end
      D_RD: begin
        mem_req  = 1'b1;
        mem_addr = d_addr_q;
      end
      D_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = d_addr_q;
        mem_wdata = d_wdata_q;
      end
      default: ;
    endcase
  end

  assign i_line_done = (state == DONE) && done_is_i;
  assign d_ready     = (state == DONE) && !done_is_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_i <= 1'b0;
      done_is_i    <= 1'b0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      i_word       <= '0;
      i_word_idx   <= '0;
      i_word_ready <= 1'b0;
      d_rdata      <= '0;
    end else begin
      i_word_ready <= i_accept;
      if (i_accept) begin
        i_word     <= mem_rdata;
        i_word_idx <= recv_idx;
        recv_cnt   <= recv_next;
      end

      case (state)
        IDLE: begin
          if (grant_i) begin
            state        <= I_ISSUE;
            i_addr_q     <= i_addr;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            last_grant_i <= 1'b1;
            done_is_i    <= 1'b1;
          end else if (grant_d) begin
            state        <= d_we ? D_WR : D_RD;
            d_addr_q     <= d_addr;
            d_wdata_q    <= d_wdata;
            last_grant_i <= 1'b0;
            done_is_i    <= 1'b0;
          end
        end
        I_ISSUE: begin
          issue_cnt <= issue_cnt + CNT_ONE;
          if (issue_cnt == CNT_LAST)
            state <= (recv_next == CNT_FULL) ? DONE : I_WAIT;
        end
        // DONE lines up with the pulse of the final word being registered now.
        I_WAIT: begin
          if (recv_next == CNT_FULL)
            state <= DONE;
        end
        D_RD: state <= D_WAIT;
        D_WAIT: begin
          if (mem_rvalid) begin
            d_rdata <= mem_rdata;
            state   <= DONE;
          end
        end
        D_WR: state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: variable-latency memory environment, directed
// scenarios and random single-requester traffic checked against a line/word model.
module tb_mem_port_arbiter;

  localparam int LW = 4;
  localparam int OP_I = 0, OP_DR = 1, OP_DW = 2, OP_DBOTH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_addr;
  logic [31:0] i_word;
  logic [1:0]  i_word_idx;
  logic        i_word_ready;
  logic        i_line_done;
  logic        d_re;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int fixed_lat = 1;
  int inject_cnt = 0;
  int inject_done = 0;
  int last_due = 0;
  int m_lat, m_due;
  int rq_due[$];
  logic [31:0] rq_data[$];
  logic [31:0] env_mem [logic [15:0]];
  logic [31:0] ref_mem [logic [15:0]];

  bit          cmd_we[$];
  logic [15:0] cmd_addr[$];
  logic [31:0] cmd_wdata[$];
  int          cmd_cyc[$];
  logic [1:0]  iw_idx[$];
  logic [31:0] iw_word[$];
  int          iw_cyc[$];
  int          ld_cyc[$];
  logic [31:0] dr_data[$];
  int          dr_cyc[$];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr), .i_word(i_word), .i_word_idx(i_word_idx),
    .i_word_ready(i_word_ready), .i_line_done(i_line_done),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    if (a == 16'h0040) return 32'hDEADBEEF;
    return {a ^ 16'h5A5A, ~a};
  endfunction

  function automatic logic [31:0] env_read(input logic [15:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // Word k of a refill: same line, offset advanced by k and wrapped.
  function automatic logic [15:0] line_addr(input logic [15:0] a, input int k);
    int base, off;
    base = (int'(a) / LW) * LW;
    off  = (int'(a) % LW + k) % LW;
    return 16'(base + off);
  endfunction

  // Memory environment: commands seen just after the edge, reads answered in order.
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq_data.pop_front();
      void'(rq_due.pop_front());
    end else if (inject_done != inject_cnt) begin
      mem_rvalid  = 1'b1;
      mem_rdata   = 32'hBAD00BAD;
      inject_done = inject_done + 1;
    end
    if (mem_req) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else begin
        m_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(4, 1));
        m_due = cyc + m_lat;
        if (m_due <= last_due) m_due = last_due + 1;
        last_due = m_due;
        rq_due.push_back(m_due);
        rq_data.push_back(env_read(mem_addr));
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req) begin
      cmd_we.push_back(mem_we);
      cmd_addr.push_back(mem_addr);
      cmd_wdata.push_back(mem_wdata);
      cmd_cyc.push_back(cyc);
    end
    if (i_word_ready) begin
      iw_idx.push_back(i_word_idx);
      iw_word.push_back(i_word);
      iw_cyc.push_back(cyc);
    end
    if (i_line_done) ld_cyc.push_back(cyc);
    if (d_ready) begin
      dr_data.push_back(d_rdata);
      dr_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ctrl"},
                64'({mem_req, mem_we, i_word_ready, i_line_done, d_ready, i_word_idx, mem_addr}), 64'(0));
    checkOutput({tag, "_data"}, 64'(i_word | d_rdata | mem_wdata), 64'(0));
  endtask

  // One complete transaction from a single requester, checked against the model.
  task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [31:0] wdata,
                               input int lat);
    int c, cm, im, lm, dm, budget;
    bit done;
    fixed_lat = (lat == 0) ? 0 : lat;
    cm = cmd_addr.size(); im = iw_idx.size(); lm = ld_cyc.size(); dm = dr_cyc.size();
    @(negedge clk);
    c = cyc;
    d_wdata = wdata;
    case (kind)
      OP_I:    begin i_miss = 1'b1; i_addr = addr; end
      OP_DR:   begin d_re = 1'b1; d_addr = addr; end
      OP_DW:   begin d_we = 1'b1; d_addr = addr; end
      default: begin d_re = 1'b1; d_we = 1'b1; d_addr = addr; end
    endcase
    done = 1'b0;
    budget = 0;
    while (!done && budget < 60) begin
      @(negedge clk);
      budget++;
      if (budget == 1) begin
        i_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata;
      end
      if (i_line_done || d_ready) done = 1'b1;
    end
    i_miss = 1'b0; d_re = 1'b0; d_we = 1'b0;
    checkOutput("op_timeout", 64'(done), 64'(1));
    repeat (2) @(negedge clk);

    if (kind == OP_I) begin
      checkOutput("i_cmd_count", 64'(cmd_addr.size() - cm), 64'(LW));
      for (int k = 0; k < LW; k++) begin
        if (cm + k < cmd_addr.size()) begin
          checkOutput("i_cmd_addr", 64'(cmd_addr[cm+k]), 64'(line_addr(addr, k)));
          checkOutput("i_cmd_we", 64'(cmd_we[cm+k]), 64'(0));
          checkOutput("i_cmd_cycle", 64'(cmd_cyc[cm+k]), 64'(c + 1 + k));
        end
      end
      checkOutput("i_pulse_count", 64'(iw_idx.size() - im), 64'(LW));
      for (int k = 0; k < LW; k++) begin
        if (im + k < iw_idx.size()) begin
          checkOutput("i_word_idx", 64'(iw_idx[im+k]), 64'((int'(addr) % LW + k) % LW));
          checkOutput("i_word", 64'(iw_word[im+k]), 64'(ref_read(line_addr(addr, k))));
          if (lat != 0) checkOutput("i_word_cycle", 64'(iw_cyc[im+k]), 64'(c + 2 + k + lat));
        end
      end
      checkOutput("i_line_done_count", 64'(ld_cyc.size() - lm), 64'(1));
      if (ld_cyc.size() > lm && iw_cyc.size() > 0)
        checkOutput("i_line_done_with_last", 64'(ld_cyc[lm]), 64'(iw_cyc[iw_cyc.size()-1]));
      checkOutput("i_no_d_ready", 64'(dr_cyc.size() - dm), 64'(0));
    end else begin
      checkOutput("d_cmd_count", 64'(cmd_addr.size() - cm), 64'(1));
      if (cmd_addr.size() > cm) begin
        checkOutput("d_cmd_addr", 64'(cmd_addr[cm]), 64'(addr));
        checkOutput("d_cmd_cycle", 64'(cmd_cyc[cm]), 64'(c + 1));
        checkOutput("d_cmd_we", 64'(cmd_we[cm]), 64'(kind != OP_DR));
        if (kind != OP_DR) checkOutput("d_cmd_wdata", 64'(cmd_wdata[cm]), 64'(wdata));
      end
      checkOutput("d_ready_count", 64'(dr_cyc.size() - dm), 64'(1));
      if (dr_cyc.size() > dm) begin
        if (kind == OP_DR) begin
          checkOutput("d_rdata", 64'(dr_data[dm]), 64'(ref_read(addr)));
          checkOutput("d_read_latency", 64'(dr_cyc[dm]), 64'(c + 2 + lat));
        end else begin
          checkOutput("d_write_latency", 64'(dr_cyc[dm]), 64'(c + 2));
        end
      end
      checkOutput("d_no_line_done", 64'(ld_cyc.size() - lm), 64'(0));
      if (kind != OP_DR) ref_mem[addr] = wdata;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seq[$];
    int budget, im, lm, dm, cm, kind, lat;
    logic [15:0] ra;

    rst = 1'b1; i_miss = 1'b0; i_addr = '0;
    d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    checkReset("reset");

    // Both requesters pending straight out of reset: refill first, then alternate.
    fixed_lat = 1;
    cm = cmd_addr.size(); dm = dr_cyc.size();
    rst = 1'b0; i_miss = 1'b1; d_re = 1'b1; i_addr = 16'h0230; d_addr = 16'h0077;
    budget = 0;
    while (seq.size() < 4 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (i_line_done) seq.push_back(0);
      if (d_ready) seq.push_back(1);
    end
    i_miss = 1'b0; d_re = 1'b0;
    checkOutput("alt_timeout", 64'(seq.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (k < seq.size()) checkOutput("alt_order", 64'(seq[k]), 64'(k % 2));
    if (cmd_addr.size() > cm) checkOutput("alt_first_cmd", 64'(cmd_addr[cm]), 64'(16'h0230));
    for (int k = 0; k < 2; k++)
      if (dm + k < dr_data.size()) checkOutput("alt_d_rdata", 64'(dr_data[dm+k]), 64'(ref_read(16'h0077)));
    repeat (3) @(negedge clk);

    applyStimulus(OP_I, 16'h0106, 32'h0, 2);
    applyStimulus(OP_DR, 16'h0040, 32'h0, 3);
    applyStimulus(OP_DW, 16'h0011, 32'h12345678, 1);
    applyStimulus(OP_DR, 16'h0011, 32'h0, 2);

    // Reset in the middle of a refill, after two words have come back.
    fixed_lat = 2;
    im = iw_idx.size();
    @(negedge clk);
    i_miss = 1'b1; i_addr = 16'h0305;
    budget = 0;
    while (iw_idx.size() - im < 2 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("abort_timeout", 64'(iw_idx.size() - im >= 2), 64'(1));
    rst = 1'b1; i_miss = 1'b0;
    @(negedge clk);
    checkReset("abort_reset");
    rst = 1'b0;
    im = iw_idx.size(); lm = ld_cyc.size();
    repeat (8) @(negedge clk);
    checkOutput("abort_late_pulses", 64'(iw_idx.size() - im), 64'(0));
    checkOutput("abort_no_line_done", 64'(ld_cyc.size() - lm), 64'(0));
    applyStimulus(OP_I, 16'h0305, 32'h0, 2);

    // Stray response while idle, then simultaneous read and write requests.
    im = iw_idx.size(); dm = dr_cyc.size(); cm = cmd_addr.size();
    @(negedge clk);
    inject_cnt = inject_cnt + 1;
    repeat (4) @(negedge clk);
    checkOutput("spurious_pulses", 64'(iw_idx.size() - im), 64'(0));
    checkOutput("spurious_d_ready", 64'(dr_cyc.size() - dm), 64'(0));
    checkOutput("spurious_cmds", 64'(cmd_addr.size() - cm), 64'(0));
    applyStimulus(OP_I, 16'h0400, 32'h0, 1);
    applyStimulus(OP_DBOTH, 16'h0123, 32'hCAFEF00D, 1);
    applyStimulus(OP_DR, 16'h0123, 32'h0, 3);

    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(3, 0));
      ra   = 16'($urandom_range(16'h00FF, 0));
      if (kind == OP_I && $urandom_range(1, 0) == 1) lat = 0;
      else lat = int'($urandom_range(4, 1));
      applyStimulus(kind, ra, $urandom, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
